// File: rtl/cle_blob_stats_pkg.sv
// Shared types and widths for the blob statistics stage.
// Imported by the label CAM and the top-level scanner.
package cle_blob_stats_pkg;

    localparam int LBL_BITS = 8;
    localparam int DIM_BITS = 5;
    localparam int SLOT_W   = 4;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cle_blob_stats_cam.sv
// Label CAM: one valid bit and label register per object slot.
// Provides the hit lookup, the full flag and a readback port.
module cle_lbl_cam
    import cle_blob_stats_pkg::*;
#(
    parameter int MAX_LBL = 8,
    parameter int LBL_W   = LBL_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [LBL_W-1:0]  q,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_idx,
    input  logic [SLOT_W-1:0] rd_idx,
    output logic              hit,
    output logic [SLOT_W-1:0] hit_idx,
    output logic              full,
    output logic [LBL_W-1:0]  rd_label
);

    logic [MAX_LBL-1:0] valid;
    logic [LBL_W-1:0]   lbl [MAX_LBL];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= '0;
            for (int i = 0; i < MAX_LBL; i++) lbl[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < MAX_LBL; i++) begin
                if (wr_idx == SLOT_W'(i)) begin
                    valid[i] <= 1'b1;
                    lbl[i]   <= q;
                end
            end
        end
    end

    // Labels are unique per slot, so at most one entry can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_LBL; i++) begin
            if (!hit && valid[i] && lbl[i] == q) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        rd_label = '0;
        for (int i = 0; i < MAX_LBL; i++) begin
            if (rd_idx == SLOT_W'(i)) rd_label = lbl[i];
        end
    end

    assign full = &valid;

endmodule

// File: rtl/cle_blob_stats.sv
// Raster scan of the label SRAM building a per-object area/bbox table.
// Objects are numbered in first-seen order; read back via lbl_sel.
module cle_blob_stats
    import cle_blob_stats_pkg::*;
#(
    parameter int MAX_LBL = 8,
    parameter int LBL_W   = LBL_BITS,
    parameter int DIM_LOG = DIM_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [2*DIM_LOG-1:0] sram_a,
    input  logic [LBL_W-1:0]     sram_q,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [CNT_W-1:0]     nlabels,
    input  logic [SLOT_W-1:0]    lbl_sel,
    output logic [LBL_W-1:0]     st_label,
    output logic [2*DIM_LOG:0]   st_area,
    output logic [DIM_LOG-1:0]   st_rmin,
    output logic [DIM_LOG-1:0]   st_rmax,
    output logic [DIM_LOG-1:0]   st_cmin,
    output logic [DIM_LOG-1:0]   st_cmax
);

    localparam int AW = 2 * DIM_LOG;

    state_t state, state_n;

    logic [AW-1:0]      a1;
    logic               v1;
    logic               start_ok, px, do_upd, do_alloc;
    logic               hit, full;
    logic [SLOT_W-1:0]  hit_idx;
    logic [LBL_W-1:0]   rd_label;
    logic [DIM_LOG-1:0] row, col;

    logic [AW:0]        area [MAX_LBL];
    logic [DIM_LOG-1:0] rmin [MAX_LBL];
    logic [DIM_LOG-1:0] rmax [MAX_LBL];
    logic [DIM_LOG-1:0] cmin [MAX_LBL];
    logic [DIM_LOG-1:0] cmax [MAX_LBL];

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign busy     = (state == ST_SCAN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    // a1 is the address whose data is on sram_q this cycle.
    assign row      = a1[AW-1:DIM_LOG];
    assign col      = a1[DIM_LOG-1:0];
    assign px       = v1 && (sram_q != '0);
    assign do_upd   = px && hit;
    assign do_alloc = px && !hit && !full;

    cle_lbl_cam #(
        .MAX_LBL (MAX_LBL),
        .LBL_W   (LBL_W)
    ) u_cam (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .q        (sram_q),
        .wr_en    (do_alloc),
        .wr_idx   (nlabels[SLOT_W-1:0]),
        .rd_idx   (lbl_sel),
        .hit      (hit),
        .hit_idx  (hit_idx),
        .full     (full),
        .rd_label (rd_label)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (start) state_n = ST_SCAN;
            ST_SCAN:  if (sram_a == {AW{1'b1}}) state_n = ST_DRAIN;
            ST_DRAIN: state_n = ST_DONE;
            ST_DONE:  if (start) state_n = ST_SCAN;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            sram_a  <= '0;
            a1      <= '0;
            v1      <= 1'b0;
            nlabels <= '0;
            ovf     <= 1'b0;
            for (int i = 0; i < MAX_LBL; i++) begin
                area[i] <= '0;
                rmin[i] <= '0;
                rmax[i] <= '0;
                cmin[i] <= '0;
                cmax[i] <= '0;
            end
        end else begin
            state <= state_n;
            a1    <= sram_a;
            v1    <= (state == ST_SCAN);
            if (start_ok) begin
                sram_a  <= '0;
                nlabels <= '0;
                ovf     <= 1'b0;
            end else begin
                if (state == ST_SCAN && sram_a != {AW{1'b1}})
                    sram_a <= sram_a + AW'(1);
                if (do_alloc)
                    nlabels <= nlabels + CNT_W'(1);
                if (px && !hit && full)
                    ovf <= 1'b1;
                for (int i = 0; i < MAX_LBL; i++) begin
                    if (do_upd && hit_idx == SLOT_W'(i)) begin
                        area[i] <= area[i] + (AW+1)'(1);
                        if (row < rmin[i]) rmin[i] <= row;
                        if (row > rmax[i]) rmax[i] <= row;
                        if (col < cmin[i]) cmin[i] <= col;
                        if (col > cmax[i]) cmax[i] <= col;
                    end
                    if (do_alloc && nlabels[SLOT_W-1:0] == SLOT_W'(i)) begin
                        area[i] <= (AW+1)'(1);
                        rmin[i] <= row;
                        rmax[i] <= row;
                        cmin[i] <= col;
                        cmax[i] <= col;
                    end
                end
            end
        end
    end

    always_comb begin
        st_label = '0;
        st_area  = '0;
        st_rmin  = '0;
        st_rmax  = '0;
        st_cmin  = '0;
        st_cmax  = '0;
        if (done && ({1'b0, lbl_sel} < nlabels)) begin
            st_label = rd_label;
            for (int i = 0; i < MAX_LBL; i++) begin
                if (lbl_sel == SLOT_W'(i)) begin
                    st_area = area[i];
                    st_rmin = rmin[i];
                    st_rmax = rmax[i];
                    st_cmin = cmin[i];
                    st_cmax = cmax[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_cle_blob_stats.sv
// Randomized bench for cle_blob_stats with an in-bench table model.
// Every cycle the outputs are compared against the model timeline.
module tb_cle_blob_stats;

    localparam int MAXL = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] sram_a;
    logic [7:0] sram_q;
    logic       busy, done, ovf;
    logic [4:0] nlabels;
    logic [3:0] lbl_sel = 4'd0;
    logic [7:0] st_label;
    logic [10:0] st_area;
    logic [4:0] st_rmin, st_rmax, st_cmin, st_cmax;

    logic [7:0] mem [1024];

    int vectors = 0;
    int errors  = 0;

    int e_n = 0;
    bit e_ovf = 0;
    int e_lbl [MAXL];
    int e_area [MAXL];
    int e_r0 [MAXL];
    int e_r1 [MAXL];
    int e_c0 [MAXL];
    int e_c1 [MAXL];
    bit exp_busy = 0;
    bit exp_done = 0;
    int cnt = 0;

    cle_blob_stats #(.MAX_LBL(MAXL)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sram_a   (sram_a),
        .sram_q   (sram_q),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .nlabels  (nlabels),
        .lbl_sel  (lbl_sel),
        .st_label (st_label),
        .st_area  (st_area),
        .st_rmin  (st_rmin),
        .st_rmax  (st_rmax),
        .st_cmin  (st_cmin),
        .st_cmax  (st_cmax)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[sram_a];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // Whole-image table from the object rules, computed in one pass.
    task automatic model_table();
        int q, r, c, f;
        e_n = 0;
        e_ovf = 0;
        for (int p = 0; p < 1024; p++) begin
            q = int'(mem[p]);
            r = p / 32;
            c = p % 32;
            f = -1;
            for (int s = 0; s < e_n; s++) if (e_lbl[s] == q) f = s;
            if (q == 0) begin
            end else if (f >= 0) begin
                e_area[f]++;
                if (r < e_r0[f]) e_r0[f] = r;
                if (r > e_r1[f]) e_r1[f] = r;
                if (c < e_c0[f]) e_c0[f] = c;
                if (c > e_c1[f]) e_c1[f] = c;
            end else if (e_n < MAXL) begin
                e_lbl[e_n] = q;
                e_area[e_n] = 1;
                e_r0[e_n] = r;
                e_r1[e_n] = r;
                e_c0[e_n] = c;
                e_c1[e_n] = c;
                e_n++;
            end else begin
                e_ovf = 1;
            end
        end
    endtask

    // Timeline: start accepted when not busy, done 1025 edges later.
    always @(posedge clk) begin
        if (reset) begin
            exp_busy = 0;
            exp_done = 0;
            cnt = 0;
        end else if (exp_busy) begin
            cnt++;
            if (cnt == 1025) begin
                exp_busy = 0;
                exp_done = 1;
            end
        end else if (start) begin
            exp_busy = 1;
            exp_done = 0;
            cnt = 0;
            model_table();
        end
    end

    always @(posedge clk) begin
        int s;
        #1;
        s = int'(lbl_sel);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        if (exp_busy) chk("sram_a", 32'(sram_a), (cnt > 1023) ? 1023 : cnt);
        if (exp_done) begin
            chk("nlabels", 32'(nlabels), e_n);
            chk("ovf", 32'(ovf), 32'(e_ovf));
        end
        if (exp_done && s < e_n) begin
            chk("st_label", 32'(st_label), e_lbl[s]);
            chk("st_area", 32'(st_area), e_area[s]);
            chk("st_rmin", 32'(st_rmin), e_r0[s]);
            chk("st_rmax", 32'(st_rmax), e_r1[s]);
            chk("st_cmin", 32'(st_cmin), e_c0[s]);
            chk("st_cmax", 32'(st_cmax), e_c1[s]);
        end else begin
            chk("st_zero", 32'({st_label, st_area, st_rmin, st_rmax,
                                st_cmin, st_cmax}), 0);
        end
    end

    task automatic fill_zero();
        for (int p = 0; p < 1024; p++) mem[p] = 8'h00;
    endtask

    task automatic fill_rand(input int np, input int pct);
        int base;
        base = int'($urandom_range(0, 254));
        for (int p = 0; p < 1024; p++) begin
            if (int'($urandom_range(99)) < pct)
                mem[p] = 8'(1 + ((base + 17 * int'($urandom_range(np - 1))) % 255));
            else
                mem[p] = 8'h00;
        end
    endtask

    task automatic run_scan(input string nm);
        int n;
        n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
        chk({nm, "_latency"}, n, 1025);
    endtask

    task automatic sweep();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk) lbl_sel = 4'(s);
        end
        @(negedge clk) lbl_sel = 4'd0;
    endtask

    task automatic rb_lit(input int s, input int l, input int a,
                          input int r0, input int r1,
                          input int c0, input int c1);
        @(negedge clk) lbl_sel = 4'(s);
        #1;
        chk("lit_label", 32'(st_label), l);
        chk("lit_area", 32'(st_area), a);
        chk("lit_rmin", 32'(st_rmin), r0);
        chk("lit_rmax", 32'(st_rmax), r1);
        chk("lit_cmin", 32'(st_cmin), c0);
        chk("lit_cmax", 32'(st_cmax), c1);
    endtask

    task automatic wait_addr(input int a);
        int n;
        n = 0;
        while (sram_a != 10'(a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_addr", 32'(sram_a), a);
    endtask

    initial begin
        fill_zero();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_nlabels", 32'(nlabels), 0);
        chk("rst_sram_a", 32'(sram_a), 0);
        chk("rst_area", 32'(st_area), 0);

        run_scan("zero");
        chk("zero_n", 32'(nlabels), 0);
        chk("zero_ovf", 32'(ovf), 0);
        sweep();

        fill_zero();
        for (int r = 2; r <= 4; r++)
            for (int c = 3; c <= 6; c++) mem[r * 32 + c] = 8'h05;
        run_scan("rect");
        chk("rect_n", 32'(nlabels), 1);
        rb_lit(0, 8'h05, 12, 2, 4, 3, 6);
        rb_lit(1, 0, 0, 0, 0, 0, 0);

        fill_zero();
        mem[0] = 8'h10;
        mem[1023] = 8'h20;
        run_scan("corner");
        chk("corner_n", 32'(nlabels), 2);
        rb_lit(0, 8'h10, 1, 0, 0, 0, 0);
        rb_lit(1, 8'h20, 1, 31, 31, 31, 31);

        fill_rand(5, 60);
        run_scan("five");
        sweep();

        for (int p = 0; p < 1024; p++)
            mem[p] = ($urandom_range(1) != 0) ? 8'(1 + $urandom_range(7)) : 8'h00;
        for (int p = 0; p < 8; p++) mem[p] = 8'(p + 1);
        for (int k = 0; k < 20; k++) mem[$urandom_range(1023, 8)] = 8'h09;
        run_scan("nine");
        chk("nine_n", 32'(nlabels), 8);
        chk("nine_ovf", 32'(ovf), 1);
        rb_lit(8, 0, 0, 0, 0, 0, 0);
        sweep();

        for (int t = 0; t < 4; t++) begin
            fill_rand(int'($urandom_range(12, 1)), int'($urandom_range(95, 5)));
            run_scan("rand");
            sweep();
        end

        fill_rand(6, 50);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_addr(200);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_addr(500);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_nlabels", 32'(nlabels), 0);
        run_scan("after_rst");
        sweep();
        fill_rand(3, 30);
        run_scan("restart");
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
